// File: rtl/phase_seq_pkg.sv
// rtl/phase_seq_pkg.sv - shared types and helpers for the phase sequencer
// Purpose: FSM state encoding and index-width helper shared by the sequencer,
// its interface and its bench.
package phase_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    STEP  = 2'd3
  } state_e;

  // Width needed to index n phases, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// rtl/phase_sequencer_if.sv - control/status bundle of the phase sequencer
// Purpose: groups the request inputs and phase-enable outputs.
// Ports (master = requester, slave = sequencer):
//   enable, stepReq, holdCycles            requester -> sequencer
//   phaseOut, phaseIdx, phaseStart,
//   cycleDone, stepAck, busy               sequencer -> requester
interface phase_sequencer_if #(
  parameter int NUM_PHASES = 4,
  parameter int CNT_WIDTH  = 8
);
  import phase_seq_pkg::*;

  localparam int IDX_WIDTH = idx_width(NUM_PHASES);

  logic                  enable;
  logic                  stepReq;
  logic [CNT_WIDTH-1:0]  holdCycles;
  logic [NUM_PHASES-1:0] phaseOut;
  logic [IDX_WIDTH-1:0]  phaseIdx;
  logic                  phaseStart;
  logic                  cycleDone;
  logic                  stepAck;
  logic                  busy;

  modport master (
    output enable, stepReq, holdCycles,
    input  phaseOut, phaseIdx, phaseStart, cycleDone, stepAck, busy
  );

  modport slave (
    input  enable, stepReq, holdCycles,
    output phaseOut, phaseIdx, phaseStart, cycleDone, stepAck, busy
  );

endinterface

// File: rtl/phase_sequencer_counter.sv
// rtl/phase_sequencer_counter.sv - phase-length down-counter
// Purpose: loadable down-counter that saturates at zero and flags terminal.
// Ports:
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   load_i           load load_val_i (has priority over dec_i)
//   load_val_i       value loaded at phase start
//   dec_i            decrement while non-zero
//   zero_o           counter is zero (last cycle of the phase)
module phase_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 load_i,
  input  logic [CNT_WIDTH-1:0] load_val_i,
  input  logic                 dec_i,
  output logic                 zero_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      // Saturating at zero keeps an all-ones load from wrapping early.
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - multi-phase one-hot clock-enable sequencer
// Purpose: rotates NUM_PHASES one-hot enables, each lasting holdCycles+1
// cycles, in free-running, drain-to-stop or single-step mode.
// Ports:
//   clkIn   sole clock
//   rstN    asynchronous active-low reset
//   bus     phase_sequencer_if slave (requests in, phase enables out)
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic            clkIn,
  input  logic            rstN,
  phase_sequencer_if.slave bus
);

  localparam int IDX_WIDTH = idx_width(NUM_PHASES);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_PHASES - 1);

  state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic                 start_q, start_d;
  logic                 en_q, step_q;
  logic                 load;
  logic                 cnt_zero;
  logic                 busy;
  logic                 last_cycle;

  // Requests are registered before the FSM sees them, so nothing on the
  // output side depends combinationally on an input pin.
  always_ff @(posedge clkIn or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      idx_q   <= '0;
      start_q <= 1'b0;
      en_q    <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      start_q <= start_d;
      en_q    <= bus.enable;
      step_q  <= bus.stepReq;
    end
  end

  assign busy       = (state_q != IDLE);
  assign last_cycle = busy && (idx_q == LAST_IDX) && cnt_zero;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    start_d = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        // enable has priority; a simultaneous stepReq is simply dropped.
        if (en_q || step_q) begin
          state_d = en_q ? RUN : STEP;
          idx_d   = '0;
          load    = 1'b1;
          start_d = 1'b1;
        end
      end
      RUN, DRAIN: begin
        // RUN and DRAIN only differ in what happens at the cycle boundary,
        // so enable returning during DRAIN resumes without a gap.
        state_d = en_q ? RUN : DRAIN;
        if (cnt_zero) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (en_q) begin
              load    = 1'b1;
              start_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d   = idx_q + IDX_WIDTH'(1);
            load    = 1'b1;
            start_d = 1'b1;
          end
        end
      end
      STEP: begin
        if (cnt_zero) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + IDX_WIDTH'(1);
            load    = 1'b1;
            start_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  phase_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_counter (
    .clk_i     (clkIn),
    .rst_n_i   (rstN),
    .load_i    (load),
    .load_val_i(bus.holdCycles),
    .dec_i     (busy),
    .zero_o    (cnt_zero)
  );

  // Outputs are decodes of registered state only; reset clears them at once.
  assign bus.phaseOut   = busy ? (NUM_PHASES'(1) << idx_q) : '0;
  assign bus.phaseIdx   = idx_q;
  assign bus.phaseStart = start_q;
  assign bus.cycleDone  = last_cycle;
  assign bus.stepAck    = last_cycle && (state_q == STEP);
  assign bus.busy       = busy;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - scoreboard bench for phase_sequencer
module tb_phase_sequencer;
  localparam int N  = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  phase_sequencer_if #(.NUM_PHASES(N), .CNT_WIDTH(CW)) bus ();

  phase_sequencer #(.NUM_PHASES(N), .CNT_WIDTH(CW)) dut (
    .clkIn(clk),
    .rstN (rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [N-1:0] po;
    logic [1:0]   idx;
    logic         ps;
    logic         cd;
    logic         sa;
    logic         busy;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   busy_cnt, ack_cnt;

  // Reference model: phase number, cycles left in the phase, mode flags.
  // Requests take effect one edge after they are sampled.
  bit m_act, m_stepping, m_first, m_en_s, m_st_s;
  int m_phase, m_left;

  task automatic model_reset();
    m_act = 0; m_stepping = 0; m_first = 0; m_en_s = 0; m_st_s = 0;
    m_phase = 0; m_left = 0;
  endtask

  task automatic model_edge();
    int len;
    len = int'(bus.holdCycles) + 1;
    if (!m_act) begin
      m_first = 0;
      if (m_en_s || m_st_s) begin
        m_act = 1; m_stepping = !m_en_s; m_phase = 0; m_left = len; m_first = 1;
      end
    end else if (m_left > 1) begin
      m_left--; m_first = 0;
    end else if (m_phase == N - 1 && (m_stepping || !m_en_s)) begin
      m_act = 0; m_stepping = 0; m_phase = 0; m_left = 0; m_first = 0;
    end else begin
      m_phase = (m_phase + 1) % N; m_left = len; m_first = 1;
    end
    m_en_s = bus.enable;
    m_st_s = bus.stepReq;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.busy = m_act;
    e.po   = m_act ? N'(1 << m_phase) : '0;
    e.idx  = 2'(m_phase);
    e.ps   = m_first;
    e.cd   = m_act && (m_phase == N - 1) && (m_left == 1);
    e.sa   = e.cd && m_stepping;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.phaseOut, bus.phaseIdx, bus.phaseStart, bus.cycleDone, bus.stepAck, bus.busy};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL outputs t=%0t: got po=%b idx=%0d ps=%b cd=%b sa=%b busy=%b, want po=%b idx=%0d ps=%b cd=%b sa=%b busy=%b",
                 $time, a.po, a.idx, a.ps, a.cd, a.sa, a.busy, e.po, e.idx, e.ps, e.cd, e.sa, e.busy);
      end
    end
  end

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic chk_idle_now(input string name);
    chk({name, "_po"}, int'(bus.phaseOut), 0);
    chk({name, "_idx"}, int'(bus.phaseIdx), 0);
    chk({name, "_ps"}, int'(bus.phaseStart), 0);
    chk({name, "_cd"}, int'(bus.cycleDone), 0);
    chk({name, "_sa"}, int'(bus.stepAck), 0);
    chk({name, "_busy"}, int'(bus.busy), 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    exp_q.push_back(model_out());
    #1;
    busy_cnt += int'(bus.busy);
    ack_cnt  += int'(bus.stepAck);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic run_until_phase(input int p);
    for (int i = 0; i < 300 && !(m_act && m_phase == p); i++) cycle();
    chk("reach_phase", (m_act && m_phase == p) ? 1 : 0, 1);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    bus.enable = 1'b0; bus.stepReq = 1'b0; bus.holdCycles = '0;
    #3;
    chk_idle_now("reset_async");
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk_idle_now("reset_hold");
    rst_n = 1'b1;

    // Free-running rotation, one phase per clock.
    bus.enable = 1'b1; bus.holdCycles = 8'd0;
    run(14);
    // Longer phases, then a hold change inside phase 1.
    bus.holdCycles = 8'd2;
    run(14);
    run_until_phase(1);
    run(1);
    bus.holdCycles = 8'd0;
    run(10);
    // Drain from phase 1.
    bus.holdCycles = 8'd1;
    run_until_phase(1);
    bus.enable = 1'b0;
    run(12);
    // Drain cancelled during phase 2.
    bus.enable = 1'b1;
    run_until_phase(1);
    bus.enable = 1'b0;
    run_until_phase(2);
    bus.enable = 1'b1;
    run(10);
    bus.enable = 1'b0;
    run(12);

    // Single step with an ignored second request mid-step.
    busy_cnt = 0; ack_cnt = 0;
    bus.holdCycles = 8'd1;
    bus.stepReq = 1'b1; cycle(); bus.stepReq = 1'b0;
    run(4);
    bus.stepReq = 1'b1; cycle(); bus.stepReq = 1'b0;
    run(12);
    chk("step_busy_cycles", busy_cnt, 8);
    chk("step_ack_count", ack_cnt, 1);

    // enable and stepReq together: RUN, never an ack.
    busy_cnt = 0; ack_cnt = 0;
    bus.enable = 1'b1; bus.stepReq = 1'b1; cycle(); bus.stepReq = 1'b0;
    run(14);
    bus.enable = 1'b0;
    run(14);
    chk("both_ack_count", ack_cnt, 0);

    // Asynchronous reset during phase 2, enable kept high.
    bus.enable = 1'b1; bus.holdCycles = 8'd1;
    run_until_phase(2);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_idle_now("reset_mid");
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk); #1;
    rst_n = 1'b1;
    run(8);

    // Maximum phase length.
    bus.holdCycles = 8'd255;
    run(4 * 256 + 8);
    bus.enable = 1'b0;
    run(1100);

    // Randomized traffic.
    bus.holdCycles = 8'd0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) bus.enable = ~bus.enable;
      bus.stepReq = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) bus.holdCycles = 8'($urandom_range(0, 3));
      cycle();
    end
    bus.enable = 1'b0; bus.stepReq = 1'b0;
    run(40);

    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Programmable multi-phase clock-enable generator for the core's cycle sequencing. It produces NUM_PHASES one-hot, non-overlapping phase enables in a fixed rotation. Each phase lasts a run-time-programmable number of clkIn cycles. The block supports free-running, drain-to-stop and single-step (one major cycle) modes, and replaces raw divided clocks with single-domain enables for all datapath stages.

## Interface
- NUM_PHASES, 4: number of phases per major cycle; must be ≥ 2.
- CNT_WIDTH, 8: width of the phase-length counter and of holdCycles.
- IDX_WIDTH, $clog2(NUM_PHASES) (minimum 1): width of phaseIdx; derived, not overridden.
- clkIn, input, 1: sole clock; all state updates on its rising edge.
- rstN, input, 1: asynchronous, active-low reset.
- enable, input, 1: level request for free-running operation.
- stepReq, input, 1: request exactly one major cycle; honoured only in IDLE.
- holdCycles, input, CNT_WIDTH: phase length minus 1; sampled only at phase start.
- phaseOut, output, NUM_PHASES: one-hot phase enable; all-zero when idle.
- phaseIdx, output, IDX_WIDTH: index of the active phase; 0 when idle.
- phaseStart, output, 1: pulse on the first cycle of every phase.
- cycleDone, output, 1: pulse on the last cycle of phase NUM_PHASES-1.
- stepAck, output, 1: pulse coincident with cycleDone that ends a STEP.
- busy, output, 1: high in any state other than IDLE.

## Operation
- States: IDLE, RUN, DRAIN, STEP.
- Reset (asynchronous, immediate, including mid-phase):
  - State goes to IDLE; phaseOut, phaseIdx, phaseStart, cycleDone, stepAck, busy and the counter are all 0.
  - Operation restarts only through a new enable or stepReq.
- IDLE transitions:
  - enable=1 goes to RUN.
  - enable=0 with stepReq=1 goes to STEP.
  - If both are asserted together, enable wins and stepReq is dropped.
- Entry to RUN or STEP:
  - phaseOut=1<<0, phaseIdx=0, phaseStart=1.
  - The counter loads holdCycles.
- Phase advance:
  - The counter decrements each cycle.
  - When the counter reaches 0, the next edge advances phaseIdx by 1. From NUM_PHASES-1 it wraps to 0.
  - At that edge the block reloads holdCycles and asserts phaseStart.
  - Each phase lasts holdCycles+1 cycles.
- holdCycles=0: one phase per clock. This gives a plain rotating one-hot with period NUM_PHASES.
- holdCycles changes mid-phase have no effect until the next phase start.
- RUN with enable=0 goes to DRAIN. The current major cycle completes.
- DRAIN behaviour:
  - enable=1 before completion returns to RUN with no gap or glitch.
  - Otherwise, the cycle after cycleDone goes to IDLE with outputs cleared.
- STEP:
  - Runs one full major cycle; stepAck=cycleDone on its last cycle, then IDLE.
  - enable and stepReq are ignored during STEP.
- stepReq in RUN, DRAIN or STEP is ignored; it is not queued.
- Invariant: phaseOut is exactly one-hot whenever busy=1, and zero otherwise.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- Start latency: enable or stepReq sampled at edge k gives phaseOut[0] high after edge k+1.
- Stop latency: IDLE is entered 1 cycle after cycleDone; phaseOut=0 from that edge.
- Major-cycle period: NUM_PHASES × (holdCycles+1) cycles, with constant holdCycles.
- phaseStart and cycleDone are one cycle wide.
  - With holdCycles=0 in phase NUM_PHASES-1, both are high in the same cycle.
  - Back-to-back cycleDone pulses are spaced exactly by the period.
- holdCycles = 2^CNT_WIDTH−1 is legal: a phase lasts 2^CNT_WIDTH cycles and the counter must not wrap early.

## Structure
- Shared package phase_seq_pkg holds:
  - The state enum typedef (IDLE, RUN, DRAIN, STEP).
  - An idx-width helper function returning max(1, $clog2(n)).
- Sub-module phase_counter: CNT_WIDTH down-counter with load, decrement and terminal (==0) flag. It is instantiated once.
- The FSM, phase index register and output decode live in phase_sequencer.

## Test plan
- Reset then enable=1 with holdCycles=0 and NUM_PHASES=4:
  - phaseOut runs 0001, 0010, 0100, 1000, 0001 on consecutive cycles starting 1 cycle after enable.
  - cycleDone is high every 4th cycle.
- holdCycles=2 in RUN: each phase lasts 3 cycles, period 12. Change holdCycles to 0 mid-phase 1: phase 1 still lasts 3 cycles and phase 2 onward lasts 1.
- Drop enable during phase 1 (holdCycles=1):
  - Phases 1–3 complete, then cycleDone.
  - The next cycle has phaseOut=0 and busy=0.
  - In a repeat where enable returns during phase 2, rotation continues with no gap.
- stepReq pulse in IDLE (holdCycles=1): exactly 8 busy cycles, stepAck with cycleDone, then IDLE. A second stepReq asserted mid-STEP produces no extra cycle.
- enable and stepReq asserted together from IDLE: RUN entered, no stepAck ever produced.
- rstN low during phase 2 of RUN: all outputs go to 0 immediately without waiting for a clock edge. With enable still high after release, phaseOut=0001 one cycle after the first edge.
